fetch_unit: RTL and testbench

Instruction-fetch stage that sits directly upstream of the IF_ID pipeline register. It owns the fetch PC, drives a variable-latency instruction-memory request/ready handshake, and handles hazard stalls and branch/jump redirects. Each cycle it presents either a fetched instruction with its PC, or a bubble flag, to IF_ID (`pc_i`, `instruction_i`, `imembubble_i`).

---
 rtl/fetch_unit.sv | 141 ++++++++++++++
 tb/tb_fetch_unit.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage feeding IF_ID: owns the fetch PC, runs the imem req/ready handshake,
// absorbs hazard stalls and applies branch/jump redirects. Optional skid buffer: FETCH_SKID_EN.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ready_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] pc_o,
    output logic [31:0] instr_o,
    output logic        imembubble_o
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] redirect_target;
    logic        run;
    logic        xfer;

`ifdef FETCH_SKID_EN
    logic        skid_v_q, skid_v_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic [31:0] skid_instr_q, skid_instr_d;
`endif

    assign redirect_target = redirect_pc_i & 32'hFFFF_FFFC;
    assign imem_addr_o     = pc_q;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        run          = (state_q == RUN);
        imembubble_o = 1'b1;
        instr_o      = 32'h0;
        pc_o         = pc_q;
`ifdef FETCH_SKID_EN
        skid_v_d     = skid_v_q;
        skid_pc_d    = skid_pc_q;
        skid_instr_d = skid_instr_q;
        // Request depends only on registered state, never on stall_i.
        imem_req_o   = run && !skid_v_q;
`else
        imem_req_o   = run && !stall_i && !redirect_i;
`endif
        xfer = imem_req_o && imem_ready_i;

        // Presentation: redirect forces a bubble, then skid, then a live transfer.
        if (!redirect_i) begin
`ifdef FETCH_SKID_EN
            if (skid_v_q) begin
                imembubble_o = 1'b0;
                instr_o      = skid_instr_q;
                pc_o         = skid_pc_q;
            end else if (xfer) begin
                imembubble_o = 1'b0;
                instr_o      = imem_rdata_i;
            end
`else
            if (xfer) begin
                imembubble_o = 1'b0;
                instr_o      = imem_rdata_i;
            end
`endif
        end

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (redirect_i) begin
                    pc_d = redirect_target;
`ifdef FETCH_SKID_EN
                    skid_v_d = 1'b0;
`endif
                end else begin
`ifdef FETCH_SKID_EN
                    if (skid_v_q) begin
                        if (!stall_i) begin
                            skid_v_d = 1'b0;
                        end
                    end else if (xfer) begin
                        pc_d = pc_q + 32'd4;
                        if (stall_i) begin
                            skid_v_d     = 1'b1;
                            skid_pc_d    = pc_q;
                            skid_instr_d = imem_rdata_i;
                        end
                    end
`else
                    if (xfer) begin
                        pc_d = pc_q + 32'd4;
                    end
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q         <= RESET_PC;
`ifdef FETCH_SKID_EN
            skid_v_q     <= 1'b0;
            skid_pc_q    <= 32'h0;
            skid_instr_q <= 32'h0;
`endif
        end else begin
            pc_q         <= pc_d;
`ifdef FETCH_SKID_EN
            skid_v_q     <= skid_v_d;
            skid_pc_q    <= skid_pc_d;
            skid_instr_q <= skid_instr_d;
`endif
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a queue-based reference model predicts every cycle's outputs,
// a separate monitor pops and compares them.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        rst_i;
    logic        start_i;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ready_i;
    logic [31:0] imem_rdata_i;
    logic [31:0] pc_o;
    logic [31:0] instr_o;
    logic        imembubble_o;

    fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .stall_i      (stall_i),
        .redirect_i   (redirect_i),
        .redirect_pc_i(redirect_pc_i),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .imem_ready_i (imem_ready_i),
        .imem_rdata_i (imem_rdata_i),
        .pc_o         (pc_o),
        .instr_o      (instr_o),
        .imembubble_o (imembubble_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        req;
        logic [31:0] addr;
        logic        bub;
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    exp_t   exp_q[$];
    entry_t skid[$];
    bit          running;
    logic [31:0] fpc;
    int checks;
    int errors;

    // Reference model: predict this cycle's outputs, then advance to the next cycle.
    task automatic cycle(input bit rst, input bit st, input bit stl, input bit rd,
                         input logic [31:0] rpc, input bit rdy);
        exp_t   e;
        entry_t ent;
        bit     req;
        bit     transfer;
        logic [31:0] data;
        @(negedge clk);
        data          = $urandom;
        rst_i         = rst;
        start_i       = st;
        stall_i       = stl;
        redirect_i    = rd;
        redirect_pc_i = rpc;
        imem_ready_i  = rdy;
        imem_rdata_i  = data;
`ifdef FETCH_SKID_EN
        req = running && (skid.size() == 0);
`else
        req = running && !stl && !rd;
`endif
        transfer = req && rdy;
        e.req   = req;
        e.addr  = fpc;
        e.bub   = 1'b1;
        e.pc    = fpc;
        e.instr = 32'h0;
        if (!rd) begin
            if (skid.size() != 0) begin
                e.bub   = 1'b0;
                e.pc    = skid[0].pc;
                e.instr = skid[0].instr;
            end else if (transfer) begin
                e.bub   = 1'b0;
                e.instr = data;
            end
        end
        exp_q.push_back(e);
        if (rst) begin
            running = 1'b0;
            fpc     = RESET_PC;
            skid.delete();
        end else if (!running) begin
            if (st) running = 1'b1;
        end else if (rd) begin
            fpc = {rpc[31:2], 2'b00};
            skid.delete();
        end else if (skid.size() != 0) begin
            if (!stl) void'(skid.pop_front());
        end else if (transfer) begin
            if (stl) begin
                ent.pc    = fpc;
                ent.instr = data;
                skid.push_back(ent);
            end
            fpc = fpc + 32'd4;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: compares the DUT against the oldest prediction each cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("imem_req", {31'h0, imem_req_o}, {31'h0, e.req});
                chk("imem_addr", imem_addr_o, e.addr);
                chk("bubble", {31'h0, imembubble_o}, {31'h0, e.bub});
                chk("pc", pc_o, e.pc);
                chk("instr", instr_o, e.instr);
                if (!e.bub) $display("txn pc=%h instr=%h", e.pc, e.instr);
            end
        end
    end

    initial begin
        logic [31:0] tgt;
        checks        = 0;
        errors        = 0;
        rst_i         = 1'b1;
        start_i       = 1'b0;
        stall_i       = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'h0;
        imem_ready_i  = 1'b0;
        imem_rdata_i  = 32'h0;
        running       = 1'b0;
        fpc           = RESET_PC;
        repeat (2) @(posedge clk);

        // Reset/idle values, redirect ignored in IDLE, then start.
        cycle(1, 0, 0, 0, 32'h0, 1);
        cycle(0, 0, 0, 1, 32'h40, 1);
        cycle(0, 1, 0, 0, 32'h0, 1);
        // Zero-wait streaming, then two wait states at addr 8.
        cycle(0, 0, 0, 0, 32'h0, 1);
        cycle(0, 0, 0, 0, 32'h0, 1);
        cycle(0, 0, 0, 0, 32'h0, 0);
        cycle(0, 0, 0, 0, 32'h0, 0);
        cycle(0, 0, 0, 0, 32'h0, 1);
        cycle(0, 0, 0, 0, 32'h0, 1);
        // Three-cycle stall at addr 16, drain, continue at 20.
        for (int i = 0; i < 3; i++) cycle(0, 0, 1, 0, 32'h0, 1);
        cycle(0, 0, 0, 0, 32'h0, 1);
        cycle(0, 0, 0, 0, 32'h0, 1);
        // Redirect during a ready cycle at addr 24.
        cycle(0, 0, 0, 1, 32'h0000_0103, 1);
        cycle(0, 0, 0, 0, 32'h0, 1);
        // PC wrap from FFFF_FFFC.
        cycle(0, 0, 0, 1, 32'hFFFF_FFFE, 1);
        cycle(0, 0, 0, 0, 32'h0, 1);
        cycle(0, 0, 0, 0, 32'h0, 1);
        // Redirect + stall together, then stall into skid and reset while it is held.
        cycle(0, 0, 1, 1, 32'h0000_0200, 1);
        cycle(0, 0, 1, 0, 32'h0, 1);
        cycle(0, 0, 1, 0, 32'h0, 1);
        cycle(1, 0, 1, 0, 32'h0, 1);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 32'h0, 1);
        cycle(0, 1, 0, 0, 32'h0, 1);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                              : $urandom;
            cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) == 0),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 11) == 0),
                  tgt, ($urandom_range(0, 9) < 7));
        end

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: pending %0d expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
